// File: rtl/term_pkg.sv
// Shared constants and state encoding for the text-terminal controller.
package term_pkg;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_MAX = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } state_t;

endpackage

// File: rtl/term_fifo.sv
// Synchronous FIFO with show-ahead read data; never overwrites when full.
module term_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // extra MSB distinguishes full from empty when the indices match
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // pointer update; reset empties the queue
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // storage write, no reset needed on the data array
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/term_ctrl.sv
// Text-terminal controller: byte FIFO, cursor tracking, vmem writes,
// clear-screen and circular-row-base scrolling.
module term_ctrl
    import term_pkg::*;
#(
    parameter int COLS       = 70,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 8,
    parameter int XW         = $clog2(COLS),
    parameter int YW         = $clog2(ROWS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_char,
    output logic          in_ready,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [7:0]    wr_char,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic [YW-1:0] row_base,
    output logic          busy
);
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [YW:0]   ROWS_W = (YW+1)'(ROWS);

    state_t        state;
    logic [XW-1:0] clr_x;
    logic [YW-1:0] clr_y;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          fifo_pop;

    logic [YW:0]   psum;
    logic [YW-1:0] prow;
    logic [YW-1:0] rb_inc;
    logic          is_print;
    logic          is_nl;
    logic          is_bs;
    logic          is_ff;
    logic          do_nl;

    assign in_ready = !fifo_full && (state != CLR_ALL);
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign busy     = (state != IDLE) || !fifo_empty;

    term_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid && in_ready),
        .din   (in_char),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // physical row: sum is < 2*ROWS, so a single conditional subtract wraps it
    assign psum   = {1'b0, row_base} + {1'b0, cur_y};
    assign prow   = (psum >= ROWS_W) ? YW'(psum - ROWS_W) : YW'(psum);
    assign rb_inc = (row_base == Y_LAST) ? '0 : row_base + YW'(1);

    assign is_print = (fifo_dout >= CH_SP) && (fifo_dout <= CH_MAX);
    assign is_nl    = (fifo_dout == CH_LF) || (fifo_dout == CH_CR);
    assign is_bs    = (fifo_dout == CH_BS);
    assign is_ff    = (fifo_dout == CH_FF);
    // printable in the last column wraps exactly like a newline
    assign do_nl    = is_nl || (is_print && (cur_x == X_LAST));

    // control FSM: decode popped bytes, sequence clears, drive registered writes
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLR_ALL;
            clr_x    <= '0;
            clr_y    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            row_base <= '0;
            wr_en    <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_char  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (is_print) begin
                            wr_en   <= 1'b1;
                            wr_x    <= cur_x;
                            wr_y    <= prow;
                            wr_char <= fifo_dout;
                        end
                        if (is_bs && (cur_x != '0)) begin
                            wr_en   <= 1'b1;
                            wr_x    <= cur_x - XW'(1);
                            wr_y    <= prow;
                            wr_char <= CH_SP;
                            cur_x   <= cur_x - XW'(1);
                        end
                        if (do_nl) begin
                            cur_x <= '0;
                            if (cur_y != Y_LAST) begin
                                cur_y <= cur_y + YW'(1);
                            end else begin
                                // old top row becomes the new bottom row; blank it
                                row_base <= rb_inc;
                                clr_x    <= '0;
                                clr_y    <= row_base;
                                state    <= CLR_ROW;
                            end
                        end else if (is_print) begin
                            cur_x <= cur_x + XW'(1);
                        end
                        if (is_ff) begin
                            clr_x <= '0;
                            clr_y <= '0;
                            state <= CLR_ALL;
                        end
                    end
                end
                CLR_ROW: begin
                    wr_en   <= 1'b1;
                    wr_x    <= clr_x;
                    wr_y    <= clr_y;
                    wr_char <= CH_SP;
                    if (clr_x == X_LAST) state <= IDLE;
                    else                 clr_x <= clr_x + XW'(1);
                end
                CLR_ALL: begin
                    wr_en   <= 1'b1;
                    wr_x    <= clr_x;
                    wr_y    <= clr_y;
                    wr_char <= CH_SP;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            cur_x    <= '0;
                            cur_y    <= '0;
                            row_base <= '0;
                            state    <= IDLE;
                        end else begin
                            clr_y <= clr_y + YW'(1);
                        end
                    end else begin
                        clr_x <= clr_x + XW'(1);
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl on a 4x3 grid with a 4-entry FIFO.
module tb_term_ctrl;
    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int DEPTH = 4;
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_char = 8'h00;
    logic          in_ready;
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [7:0]    wr_char;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [YW-1:0] row_base;
    logic          busy;

    term_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_char(wr_char), .cur_x(cur_x), .cur_y(cur_y), .row_base(row_base),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { int x; int y; int ch; } wr_t;
    typedef struct { logic [7:0] ch; int ex; int ey; int erb; } vec_t;

    wr_t        exp_q[$];
    vec_t       tbl[$];
    logic [7:0] feed_q[$];
    int         wr_cyc_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         mx = 0, my = 0, mrb = 0;
    bit         last_ready;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_wr(input int x, input int y, input int ch);
        wr_t w;
        w.x = x; w.y = y; w.ch = ch;
        exp_q.push_back(w);
    endtask

    task automatic model_clr();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                push_wr(x, y, 8'h20);
        mx = 0; my = 0; mrb = 0;
    endtask

    task automatic model_nl();
        mx = 0;
        if (my < ROWS - 1) my++;
        else begin
            for (int x = 0; x < COLS; x++) push_wr(x, mrb, 8'h20);
            mrb = (mrb + 1) % ROWS;
        end
    endtask

    // reference behaviour; expected writes queued at acceptance time
    task automatic model_byte(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            push_wr(mx, (mrb + my) % ROWS, ch);
            if (mx == COLS - 1) model_nl();
            else mx++;
        end else if (ch == 8'h0A || ch == 8'h0D) begin
            model_nl();
        end else if (ch == 8'h08) begin
            if (mx > 0) begin
                mx--;
                push_wr(mx, (mrb + my) % ROWS, 8'h20);
            end
        end else if (ch == 8'h0C) begin
            model_clr();
        end
    endtask

    // one clock: sample handshake mid-cycle, compare any write after the edge
    task automatic tick(output bit acc);
        logic [7:0] ch;
        wr_t e;
        @(negedge clock);
        acc = in_valid && in_ready && !reset;
        last_ready = in_ready;
        ch = in_char;
        @(posedge clock);
        #1;
        cyc++;
        if (acc) model_byte(ch);
        if (wr_en === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_wr", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_x", int'(wr_x), e.x);
                check("wr_y", int'(wr_y), e.y);
                check("wr_char", int'(wr_char), e.ch);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit acc;
        int n = 0;
        do begin
            tick(acc);
            n++;
        end while (busy && n < 200);
        if (busy) fail({tag, "_idle"});
        check({tag, "_pending_wr"}, exp_q.size(), 0);
    endtask

    task automatic send_byte(input logic [7:0] ch);
        bit acc;
        int n = 0;
        in_valid = 1'b1;
        in_char = ch;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) fail("send_accept");
    endtask

    task automatic feed(output int first_acc, output bit full_seen);
        bit acc;
        int k = 0;
        first_acc = -1;
        full_seen = 0;
        while (feed_q.size() > 0 && k < 200) begin
            in_valid = 1'b1;
            in_char = feed_q[0];
            k++;
            tick(acc);
            if (!last_ready) full_seen = 1;
            if (acc) begin
                void'(feed_q.pop_front());
                if (first_acc < 0) first_acc = k;
            end
        end
        in_valid = 1'b0;
        if (feed_q.size() > 0) fail("feed");
    endtask

    task automatic check_cur(input string tag, input int ex, input int ey, input int erb);
        check({tag, "_cur_x"}, int'(cur_x), ex);
        check({tag, "_cur_y"}, int'(cur_y), ey);
        check({tag, "_row_base"}, int'(row_base), erb);
        check({tag, "_model_x"}, mx, ex);
        check({tag, "_model_y"}, my, ey);
        check({tag, "_model_rb"}, mrb, erb);
    endtask

    task automatic reset_dut();
        bit acc;
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        mx = 0; my = 0; mrb = 0;
        tick(acc);
        tick(acc);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_x", int'(wr_x), 0);
        check("rst_wr_y", int'(wr_y), 0);
        check("rst_wr_char", int'(wr_char), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 1);
        check_cur("rst", 0, 0, 0);
        reset = 1'b0;
        model_clr();
        wait_idle("post_rst");
        check("idle_busy", int'(busy), 0);
        check("idle_in_ready", int'(in_ready), 1);
        check_cur("post_rst", 0, 0, 0);
    endtask

    task automatic add(input logic [7:0] ch, input int ex, input int ey, input int erb);
        vec_t v;
        v.ch = ch; v.ex = ex; v.ey = ey; v.erb = erb;
        tbl.push_back(v);
    endtask

    initial begin
        bit acc;
        int c1, first_acc;
        bit full_seen;

        // cursor/row_base after each byte, starting from (2,0) rb=0
        add(8'h0C, 0, 0, 0); add(8'h41, 1, 0, 0); add(8'h42, 2, 0, 0);
        add(8'h43, 3, 0, 0); add(8'h44, 0, 1, 0); add(8'h45, 1, 1, 0);
        add(8'h0A, 0, 2, 0); add(8'h51, 1, 2, 0); add(8'h0D, 0, 2, 1);
        add(8'h5A, 1, 2, 1); add(8'h0A, 0, 2, 2); add(8'h61, 1, 2, 2);
        add(8'h62, 2, 2, 2); add(8'h08, 1, 2, 2); add(8'h08, 0, 2, 2);
        add(8'h08, 0, 2, 2); add(8'h07, 0, 2, 2); add(8'hFF, 0, 2, 2);
        add(8'h7E, 1, 2, 2); add(8'h1F, 1, 2, 2); add(8'h78, 2, 2, 2);
        add(8'h79, 3, 2, 2); add(8'h7A, 0, 2, 0); add(8'h0C, 0, 0, 0);
        add(8'h4B, 1, 0, 0); add(8'h4C, 2, 0, 0); add(8'h08, 1, 0, 0);

        reset_dut();

        // back-to-back bytes: writes one cycle after each pop, no bubble
        wr_cyc_q.delete();
        in_valid = 1'b1;
        in_char = 8'h41;
        tick(acc);
        if (!acc) fail("ab_accept_a");
        c1 = cyc;
        in_char = 8'h42;
        tick(acc);
        if (!acc) fail("ab_accept_b");
        in_valid = 1'b0;
        wait_idle("ab");
        check("ab_wr_count", wr_cyc_q.size(), 2);
        if (wr_cyc_q.size() == 2) begin
            check("ab_wr_a_cycle", wr_cyc_q[0], c1 + 1);
            check("ab_wr_b_cycle", wr_cyc_q[1], c1 + 2);
        end
        check_cur("ab", 2, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            send_byte(tbl[i].ch);
            wait_idle($sformatf("vec%0d", i));
            check_cur($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].erb);
        end

        // bytes held during a full clear are refused until it finishes
        send_byte(8'h0C);
        tick(acc);
        feed_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        feed(first_acc, full_seen);
        check("clr_all_first_accept", first_acc, 13);
        wait_idle("clr_hold");
        check_cur("clr_hold", 2, 1, 0);

        // FIFO fills during row clears; nothing dropped or reordered
        feed_q = '{8'h0A, 8'h0A, 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C};
        feed(first_acc, full_seen);
        check("fifo_full_seen", int'(full_seen), 1);
        wait_idle("fill");
        check_cur("fill", 2, 2, 2);

        // reset in the middle of a clear aborts it
        send_byte(8'h0C);
        for (int i = 0; i < 6; i++) tick(acc);
        reset_dut();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
